// File: rtl/down_count_monitor_if.sv
// Output handshake bundle of the down-counter monitor: buffer head value
// with its valid flag toward the consumer and the consumer's ready flag back.
interface down_count_monitor_if #(
    parameter int WIDTH = 4
) ();
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;

    modport master (
        output out_valid,
        output out_value,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        output out_ready
    );
endinterface

// File: rtl/down_count_monitor.sv
// Capture and check stage for a ripple down counter.
// The unsynchronised count bus goes through a two-flop synchroniser and a
// run-length filter. Each settled value is checked against the previous one
// minus one. Accepted values are queued in a two-entry valid/ready buffer.
module down_count_monitor #(
    parameter int WIDTH  = 4,
    parameter int STABLE = 2,
    parameter int WRAP_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  clr,
    down_count_monitor_if.master  buf_if,
    output logic                  tc,
    output logic                  seq_err,
    output logic                  ovf,
    output logic [WRAP_W-1:0]     wrap_cnt
);

    localparam int               RUN_W    = $clog2(STABLE + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE);
    localparam logic [RUN_W-1:0] RUN_EVT  = RUN_W'(STABLE - 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    // Synchroniser and sample-valid pipe
    logic [WIDTH-1:0]  r_s1;
    logic [WIDTH-1:0]  r_s2;
    logic              r_v1;
    logic              r_v2;

    // Stability filter
    logic [WIDTH-1:0]  r_cand;
    logic [RUN_W-1:0]  r_run;

    // Sequence checker and statistics
    logic              r_have_last;
    logic [WIDTH-1:0]  r_last;
    logic              r_tc;
    logic              r_seq_err;
    logic              r_ovf;
    logic [WRAP_W-1:0] r_wrap;

    // Two-entry output buffer
    logic [WIDTH-1:0]  r_mem [0:1];
    logic              r_rd;
    logic              r_wr;
    logic [1:0]        r_cnt;

    logic              w_event;
    logic              w_hl;
    logic              w_dup;
    logic              w_accept;
    logic [WIDTH-1:0]  w_pred;
    logic              w_bad;
    logic              w_wrap;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // An event fires once per stable episode, when the run reaches STABLE.
    assign w_event  = r_v2 && (r_s2 == r_cand) && (r_run == RUN_EVT);
    // A clear in the same cycle makes the event behave as the first one seen.
    assign w_hl     = r_have_last && !clr;
    // A glitch that settles back to the last accepted value is ignored.
    assign w_dup    = w_hl && (r_cand == r_last);
    assign w_accept = w_event && !w_dup;
    assign w_pred   = r_last - ONE;
    assign w_bad    = w_accept && w_hl && (r_cand != w_pred);
    assign w_wrap   = w_accept && w_hl && (r_last == '0) && (r_cand == ALL_ONES);

    assign w_valid  = (r_cnt != 2'd0);
    assign w_full   = (r_cnt == 2'd2);
    assign w_pop    = w_valid && buf_if.out_ready;
    // A pop in the same cycle frees the slot a full buffer needs.
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_drop   = w_accept && w_full && !w_pop;

    // Sample the asynchronous bus twice and mark which samples are real.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_s1 <= count_in;
            r_s2 <= r_s1;
            r_v1 <= 1'b1;
            r_v2 <= r_v1;
        end
    end

    // Track the current candidate value and how long it has been seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand <= '0;
            r_run  <= '0;
        end else if (r_v2) begin
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_run  <= RUN_ONE;
            end else if (r_run != RUN_MAX) begin
                r_run  <= r_run + RUN_ONE;
            end
        end
    end

    // Check accepted values and maintain the sticky flags and wrap count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_have_last <= 1'b0;
            r_last      <= '0;
            r_tc        <= 1'b0;
            r_seq_err   <= 1'b0;
            r_ovf       <= 1'b0;
            r_wrap      <= '0;
        end else begin
            r_tc <= w_accept && (r_cand == '0);
            if (w_accept) begin
                r_last      <= r_cand;
                r_have_last <= 1'b1;
            end else if (clr) begin
                r_have_last <= 1'b0;
            end
            if (clr) begin
                r_seq_err <= 1'b0;
                r_ovf     <= 1'b0;
                r_wrap    <= '0;
            end else begin
                if (w_bad)
                    r_seq_err <= 1'b1;
                if (w_drop)
                    r_ovf <= 1'b1;
                if (w_wrap && (r_wrap != WRAP_MAX))
                    r_wrap <= r_wrap + WRAP_ONE;
            end
        end
    end

    // Ring buffer of two entries; the head slot is never written while valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= r_cand;
                r_wr        <= ~r_wr;
            end
            if (w_pop)
                r_rd <= ~r_rd;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign buf_if.out_valid = w_valid;
    assign buf_if.out_value = r_mem[r_rd];
    assign tc               = r_tc;
    assign seq_err          = r_seq_err;
    assign ovf              = r_ovf;
    assign wrap_cnt         = r_wrap;

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: directed scenarios followed by random
// segments, checked every cycle against an event-level reference model.
module tb_down_count_monitor;

    localparam int WIDTH  = 4;
    localparam int STABLE = 2;
    localparam int WRAP_W = 3;
    localparam int WMAX   = (1 << WRAP_W) - 1;

    logic              clk;
    logic              rst;
    logic              clr;
    logic [WIDTH-1:0]  count_in;
    logic              tc;
    logic              seq_err;
    logic              ovf;
    logic [WRAP_W-1:0] wrap_cnt;

    down_count_monitor_if #(.WIDTH(WIDTH)) bus ();

    down_count_monitor #(
        .WIDTH  (WIDTH),
        .STABLE (STABLE),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .clr      (clr),
        .buf_if   (bus),
        .tc       (tc),
        .seq_err  (seq_err),
        .ovf      (ovf),
        .wrap_cnt (wrap_cnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cur;

    // Reference model: history of driven values per edge since reset,
    // a queue for the buffer and plain variables for flags.
    int hist [0:8191];
    int e;
    int mq [$];
    bit m_hl;
    int m_last;
    bit m_tc;
    bit m_err;
    bit m_ovf;
    int m_wrap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e      = 0;
        mq.delete();
        m_hl   = 1'b0;
        m_last = 0;
        m_tc   = 1'b0;
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        m_wrap = 0;
    endtask

    // Apply one clock edge to the model. A value is seen as settled on the
    // edge where it has been the synchronised sample exactly STABLE times in
    // a row (the synchroniser delays the bus by two edges).
    task automatic model_edge(input bit rdy, input bit c);
        bit ev;
        bit pop;
        bit full_pre;
        bit hl;
        int v;
        ev       = 1'b0;
        v        = 0;
        full_pre = (mq.size() == 2);
        pop      = (mq.size() > 0) && rdy;
        if (e - STABLE - 1 >= 1) begin
            v  = hist[e-2];
            ev = 1'b1;
            for (int j = 2; j <= STABLE + 1; j++)
                if (hist[e-j] != v) ev = 1'b0;
            if ((e - STABLE - 2 >= 1) && (hist[e-STABLE-2] == v)) ev = 1'b0;
        end
        if (pop) void'(mq.pop_front());
        m_tc = 1'b0;
        hl   = m_hl && !c;
        if (c) begin
            m_err  = 1'b0;
            m_ovf  = 1'b0;
            m_wrap = 0;
            m_hl   = 1'b0;
        end
        if (ev && !(hl && (v == m_last))) begin
            if (hl && (v != ((m_last + 15) % 16))) m_err = 1'b1;
            if (hl && (m_last == 0) && (v == 15) && (m_wrap < WMAX)) m_wrap++;
            if (full_pre && !pop) begin
                if (!c) m_ovf = 1'b1;
            end else begin
                mq.push_back(v);
            end
            if (v == 0) m_tc = 1'b1;
            m_last = v;
            m_hl   = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0)
            chk("out_value", 32'(bus.out_value), 32'(mq[0]));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("seq_err", 32'(seq_err), 32'(m_err));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_value"}, 32'(bus.out_value), 32'd0);
        chk({tag, "_tc"}, 32'(tc), 32'd0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap_cnt), 32'd0);
    endtask

    // One cycle: drive inputs after a falling edge, advance the model on the
    // rising edge, compare on the next falling edge.
    task automatic step(input logic [WIDTH-1:0] cin, input logic rdy, input logic c);
        count_in      = cin;
        bus.out_ready = rdy;
        clr           = c;
        cur           = int'(cin);
        @(posedge clk);
        e++;
        hist[e] = int'(cin);
        model_edge(rdy, c);
        @(negedge clk);
        clr = 1'b0;
        check_all();
    endtask

    // Hold a value for a number of cycles; rmode 0/1 fixes ready, 2 randomises it.
    task automatic seg(input int v, input int hold, input int rmode);
        for (int i = 0; i < hold; i++)
            step(WIDTH'(v), (rmode == 2) ? ($urandom_range(0, 3) != 0) : (rmode == 1), 1'b0);
    endtask

    task automatic clr_pulse(input logic rdy);
        step(WIDTH'(cur), rdy, 1'b1);
    endtask

    initial begin
        int v;
        total         = 0;
        bad           = 0;
        cur           = 0;
        rst           = 1'b1;
        clr           = 1'b0;
        count_in      = '0;
        bus.out_ready = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b1;

        // Reset start: constant 0 accepted on the fourth edge.
        seg(0, 6, 1);

        // Full descending sequence including one wrap.
        for (int k = 15; k >= 1; k--) seg(k, 4, 1);
        seg(0, 4, 1);
        chk("wrap_after_sequence", 32'(wrap_cnt), 32'd1);

        // Glitch suppression, then a glitch returning to the same value.
        clr_pulse(1'b1);
        seg(5, 4, 1);
        seg(7, 1, 1);
        seg(4, 4, 1);
        clr_pulse(1'b1);
        seg(5, 4, 1);
        seg(6, 1, 1);
        seg(5, 4, 1);

        // Sequence error, sticky, then cleared.
        clr_pulse(1'b1);
        seg(9, 4, 1);
        seg(7, 4, 1);
        seg(7, 3, 1);
        chk("seq_err_sticky", 32'(seq_err), 32'd1);
        clr_pulse(1'b1);
        seg(3, 4, 1);

        // Backpressure with overflow, then drain.
        clr_pulse(1'b1);
        seg(8, 4, 0);
        seg(7, 4, 0);
        seg(6, 4, 0);
        chk("ovf_after_third", 32'(ovf), 32'd1);
        seg(6, 3, 1);

        // Full buffer with pop and push on the same edge.
        clr_pulse(1'b1);
        seg(5, 4, 0);
        seg(4, 4, 0);
        step(4'd3, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0);
        step(4'd3, 1'b1, 1'b0);
        step(4'd3, 1'b0, 1'b0);
        chk("ovf_pop_push", 32'(ovf), 32'd0);
        seg(3, 3, 1);

        // Asynchronous reset with two entries buffered.
        seg(10, 4, 0);
        seg(9, 4, 0);
        chk("two_buffered", 32'(mq.size()), 32'd2);
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        count_in      = '0;
        cur           = 0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        seg(0, 6, 1);

        // Random segments with random ready and occasional clear.
        for (int n = 0; n < 300; n++) begin
            int hold;
            v = int'($urandom_range(0, 15));
            while (v == cur) v = int'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 5));
            for (int i = 0; i < hold; i++)
                step(WIDTH'(v), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        // Repeated full sequences drive the wrap counter into saturation.
        clr_pulse(1'b1);
        for (int r = 0; r < 9; r++)
            for (int k = 15; k >= 0; k--)
                seg(k, int'($urandom_range(2, 3)), 2);
        seg(0, 3, 1);
        chk("wrap_saturated", 32'(wrap_cnt), 32'(WMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_count_monitor.md
# down_count_monitor

Synchronous capture and checker stage directly downstream of the 4-bit asynchronous (ripple) down counter. It samples the counter's unsynchronised, transiently glitchy `count` bus and suppresses ripple transients with a stability filter. It checks that each settled value is the previous one minus 1 (mod 2^WIDTH), counts wrap-arounds, flags terminal count, and presents accepted values through a 2-entry valid/ready buffer.

## Interface
- `WIDTH`, 4: counter bus width.
- `STABLE`, 2: consecutive equal samples required to accept a value; legal range 2..15.
- `WRAP_W`, 8: width of the wrap counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `count_in` in WIDTH: ripple counter output, asynchronous to `clk`.
- `clr` in 1: synchronous clear of statistics.
- `out_ready` in 1: consumer ready.
- `out_valid` out 1: head of buffer valid.
- `out_value` out WIDTH: head of buffer.
- `tc` out 1: one-cycle pulse when 0 is accepted.
- `seq_err` out 1: sticky sequence error.
- `ovf` out 1: sticky buffer overflow.
- `wrap_cnt` out WRAP_W: saturating count of 0 -> all-ones transitions.

## Operation
- **Reset values:** all outputs are 0 while `rst`=0. Internal state also clears: sync flops `s1`/`s2`, valid pipe `v1`/`v2`, `cand`, `run`, `have_last`, `last_v`, and the buffer (empty).
- **Sampling:** `s1` <= `count_in`, `s2` <= `s1` every edge. `v1` <= 1, `v2` <= `v1` (marks real samples after reset). The filter is idle while `v2`=0.
- **Filter:**
  - If `s2` != `cand`: `cand` <= `s2`, `run` <= 1.
  - Else `run` <= min(`run`+1, `STABLE`).
  - An acceptance event fires when `s2`==`cand` and `run`==`STABLE`-1. There is exactly one event per stable episode.
- **Event processing:** let `new` = `cand`.
  - If `have_last`=1 and `new`==`last_v`: discard. No push, no flags. This covers a glitch that returns to the same value.
  - If `have_last`=0: accept with no check.
  - If `new` == `last_v`-1 mod 2^WIDTH: accept.
  - Otherwise: accept and set `seq_err`. The checker resynchronises to `new`.
  - On every accept:
    - `last_v` <= `new`, `have_last` <= 1.
    - Push `new` to the buffer.
    - `tc` = 1 for that cycle if `new`==0.
    - `wrap_cnt` increments (saturating at all-ones) if `last_v`==0 and `new`==all-ones.
- **Buffer:** 2-entry FIFO; `out_value` is the head, and `out_valid` = not empty.
  - A pop occurs on `out_valid` && `out_ready`.
  - Push when full with no pop in the same cycle: the value is dropped and `ovf` is set. `last_v`, `tc` and `wrap_cnt` still update.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - `out_value` is held stable while `out_valid`=1 and `out_ready`=0.
- **`clr`:** clears `seq_err`, `ovf`, `wrap_cnt` and `have_last`. The buffer is untouched.
  - `clr` together with an event: the event is processed as `have_last`=0 (no check, no wrap increment). Push and `tc` still occur. Flags end the cycle clear.

## Timing
- A value present on `count_in` and held from before edge k is accepted at edge k+`STABLE`+1. With an empty buffer, `out_valid`/`out_value` are visible after that edge (k+3 for `STABLE`=2).
- First edge after reset release = edge 1. A constant input is accepted at edge `STABLE`+2.
- `tc`, `seq_err`, `wrap_cnt` and `ovf` update on the acceptance edge.
- Minimum hold for a counter value to be seen: `STABLE` consecutive samples. Shorter values are filtered out.
- Asserting `rst` mid-operation clears everything immediately without waiting for a clock edge. Pending buffer contents are lost.

## Test plan
- **Reset start:** release reset with `count_in`=0 and `out_ready`=1 -> `out_valid`=1 and `out_value`=0 after edge 4. `tc` pulses once; `seq_err`=0.
- **Full sequence:** drive 0, 15, 14, ..., 1, 0, each value held 4 cycles, with `out_ready`=1 -> all 17 values emitted in order. `wrap_cnt`=1, `tc` pulses twice, `seq_err`=0.
- **Glitch suppression:** hold 5, then 7 for 1 cycle, then hold 4 -> outputs are 5 then 4, 7 is never emitted, and `seq_err`=0. Separately, 5 -> 1-cycle 6 -> 5 -> the second 5 is discarded.
- **Sequence error and clear:** hold 9, then 7 -> 7 is emitted and `seq_err`=1 and stays set. Then pulse `clr` and hold 3 -> `seq_err`=0, 3 is emitted, no new error.
- **Backpressure:** with `out_ready`=0, hold 8, 7, 6 -> buffer holds 8, 7; 6 is dropped and `ovf`=1. Then set `out_ready`=1 -> 8 then 7 on consecutive cycles. Also check a full buffer with a simultaneous pop and push -> no `ovf`.
- **Async reset:** drop `rst` between edges while 2 values are buffered -> all outputs are 0 immediately. After release, behaves as in the reset-start scenario.
